// File: rtl/mdu_ctrl_pkg.sv
// Shared op encodings and small decode helpers for the EX-stage multiply/divide sequencer.
// Op codes match the ID-stage decoder.
package mdu_ctrl_pkg;

  typedef logic [1:0] mdu_op_t;

  localparam mdu_op_t MDU_MULT  = 2'b00;
  localparam mdu_op_t MDU_MULTU = 2'b01;
  localparam mdu_op_t MDU_DIV   = 2'b10;
  localparam mdu_op_t MDU_DIVU  = 2'b11;

  function automatic logic is_div_op(input mdu_op_t op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input mdu_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer handshake, result and stall signals.
interface mdu_ctrl_if
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             flush;
  logic             ex_hold;
  logic             mdu_start;
  mdu_op_t          mdu_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stallreq_for_ex;
  logic             result_valid;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output flush, ex_hold, mdu_start, mdu_op, src_a, src_b,
    input  stallreq_for_ex, result_valid, hi_o, lo_o
  );

  modport slave (
    input  flush, ex_hold, mdu_start, mdu_op, src_a, src_b,
    output stallreq_for_ex, result_valid, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply / restoring shift-subtract divide on
// unsigned magnitudes, one result bit per step.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_raw_hi,
  output logic [WIDTH-1:0] o_raw_lo
);

  // r_hi carries one extra bit for the multiply carry / divide trial remainder
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_rem;
  logic [WIDTH+1:0] w_div_diff;
  logic             w_div_ok;

  always_comb begin
    w_mul_sum  = r_hi + ({1'b0, r_m} & {(WIDTH+1){r_lo[0]}});
    w_div_rem  = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_div_diff = {1'b0, w_div_rem} - {2'b00, r_m};
    w_div_ok   = ~w_div_diff[WIDTH+1];
  end

  // Load puts the multiplier / dividend in the low half; the other operand goes to r_m.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
      r_m  <= '0;
    end else if (i_load) begin
      r_hi <= '0;
      r_lo <= i_is_div ? i_op_a : i_op_b;
      r_m  <= i_is_div ? i_op_b : i_op_a;
    end else if (i_step) begin
      if (i_is_div) begin
        r_hi <= w_div_ok ? w_div_diff[WIDTH:0] : w_div_rem;
        r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
      end else begin
        r_hi <= {1'b0, w_mul_sum[WIDTH:1]};
        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
      r_m  <= r_m;
    end
  end

  assign o_raw_hi = r_hi[WIDTH-1:0];
  assign o_raw_lo = r_lo;

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for EX: IDLE/BUSY/DONE control, operand sign
// capture, sign fix-up of the core result, and the EX-and-earlier stall request.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mdu_ctrl_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  mdu_op_t          r_op;
  logic             r_sign_a;
  logic             r_sign_b;

  logic             w_start;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_core_is_div;
  logic [WIDTH-1:0] w_raw_hi;
  logic [WIDTH-1:0] w_raw_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  // Accept a new op only from IDLE; flush wins over a simultaneous start.
  always_comb begin
    w_start  = (r_state == S_IDLE) & bus.mdu_start & ~bus.flush;
    w_sign_a = is_signed_op(bus.mdu_op) & bus.src_a[WIDTH-1];
    w_sign_b = is_signed_op(bus.mdu_op) & bus.src_b[WIDTH-1];
    w_abs_a  = w_sign_a ? (~bus.src_a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src_a;
    w_abs_b  = w_sign_b ? (~bus.src_b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src_b;
    w_core_is_div = (r_state == S_IDLE) ? is_div_op(bus.mdu_op) : is_div_op(r_op);
  end

  // Sequencer state, iteration counter and captured op/sign bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= MDU_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else if (bus.flush) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.mdu_start) begin
            r_state  <= S_BUSY;
            r_cnt    <= '0;
            r_op     <= bus.mdu_op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_DONE: begin
          if (bus.ex_hold) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  mdu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_start),
    .i_step   (r_state == S_BUSY),
    .i_is_div (w_core_is_div),
    .i_op_a   (w_abs_a),
    .i_op_b   (w_abs_b),
    .o_raw_hi (w_raw_hi),
    .o_raw_lo (w_raw_lo)
  );

  // Sign fix-up: product negated as a whole; quotient by sign xor, remainder follows dividend.
  always_comb begin
    w_prod = {w_raw_hi, w_raw_lo};
    if (is_div_op(r_op)) begin
      w_fix_lo = (r_sign_a ^ r_sign_b) ? (~w_raw_lo + {{(WIDTH-1){1'b0}}, 1'b1}) : w_raw_lo;
      w_fix_hi = r_sign_a ? (~w_raw_hi + {{(WIDTH-1){1'b0}}, 1'b1}) : w_raw_hi;
    end else begin
      if (r_sign_a ^ r_sign_b) begin
        w_prod = ~w_prod + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
        w_prod = {w_raw_hi, w_raw_lo};
      end
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
  end

  assign bus.stallreq_for_ex = w_start | (r_state == S_BUSY);
  assign bus.result_valid    = (r_state == S_DONE);
  assign bus.hi_o            = (r_state == S_DONE) ? w_fix_hi : '0;
  assign bus.lo_o            = (r_state == S_DONE) ? w_fix_lo : '0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed corner ops, random ops against an arithmetic reference,
// hold/flush/reset behaviour.
module tb_mdu_ctrl;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mdu_ctrl_if #(.WIDTH(W)) bus ();

  mdu_ctrl #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic, divide-by-zero handled from the documented rules.
  task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, sq, sr;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin
          hi = a;
          lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          p  = 64'(sq);
          lo = p[31:0];
          p  = 64'(sr);
          hi = p[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after DONE has exited.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    logic [31:0] eh, el;
    int cyc, stalls, busy_nz;
    ref_op(op, a, b, eh, el);
    bus.mdu_start = 1'b1;
    bus.mdu_op    = op;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.ex_hold   = 1'b0;
    cyc = 0; stalls = 0; busy_nz = 0;
    @(negedge clk);
    while (bus.result_valid !== 1'b1 && cyc < 100) begin
      if (bus.stallreq_for_ex === 1'b1) stalls++;
      if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) busy_nz++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(W + 1));
    chk({tag, "_busy_out_zero"}, 64'(busy_nz), 64'd0);
    chk({tag, "_valid"}, {63'd0, bus.result_valid}, 64'd1);
    chk({tag, "_done_stall"}, {63'd0, bus.stallreq_for_ex}, 64'd0);
    chk({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, {eh, el});
    bus.ex_hold = (hold > 0);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {63'd0, bus.result_valid}, 64'd1);
      chk({tag, "_hold_hilo"}, {bus.hi_o, bus.lo_o}, {eh, el});
      if (i == hold) bus.ex_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, "_single_write"}, {63'd0, bus.result_valid}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.ex_hold = 1'b0; bus.mdu_start = 1'b0;
    bus.mdu_op = 2'b00; bus.src_a = 32'd0; bus.src_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {63'd0, bus.stallreq_for_ex}, 64'd0);
    chk("reset_valid", {63'd0, bus.result_valid}, 64'd0);
    chk("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_op(2'b11, 32'd100, 32'd7, 0, "divu_100_7");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
    do_op(2'b00, 32'hFFFF_FFFF, 32'd2, 0, "mult_m1_2");
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, "multu_max_2");
    do_op(2'b11, 32'h0000_1234, 32'd0, 0, "divu_by_zero");
    do_op(2'b10, 32'hFFFF_FF00, 32'd0, 0, "div_neg_by_zero");
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 3, "mult_hold3");
    do_op(2'b11, 32'd0, 32'd5, 1, "divu_zero_num");

    for (int n = 0; n < 16; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, $urandom_range(0, 2), "rand");
    end

    // start held high into IDLE must not restart once it drops
    bus.mdu_start = 1'b0;
    @(negedge clk);
    chk("idle_no_restart", {62'd0, bus.stallreq_for_ex, bus.result_valid}, 64'd0);

    // flush beats a same-cycle start in IDLE
    @(posedge clk);
    #1 bus.mdu_start = 1'b1; bus.flush = 1'b1; bus.mdu_op = 2'b11;
    @(negedge clk);
    chk("flush_prio_stall", {63'd0, bus.stallreq_for_ex}, 64'd0);
    @(posedge clk);
    #1 bus.mdu_start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_prio_idle", {63'd0, bus.stallreq_for_ex}, 64'd0);

    // flush mid-divide aborts with no result
    @(posedge clk);
    #1 bus.mdu_start = 1'b1; bus.mdu_op = 2'b10; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    repeat (5) @(posedge clk);
    #1 bus.mdu_start = 1'b0; bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1 || bus.stallreq_for_ex === 1'b1) seen++;
    end
    chk("flush_abort_quiet", 64'(seen), 64'd0);

    // reset at T+10 of a DIV
    @(posedge clk);
    #1 bus.mdu_start = 1'b1; bus.mdu_op = 2'b10; bus.src_a = 32'd77; bus.src_b = 32'd5;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1; bus.mdu_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_abort_stall", {63'd0, bus.stallreq_for_ex}, 64'd0);
    chk("rst_abort_valid", {63'd0, bus.result_valid}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_op(2'b01, 32'h0001_0000, 32'h0001_0003, 0, "multu_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
